alu5_op_sequencer: RTL and testbench
====================================

Name: alu5_op_sequencer

Overview:
- Registered front-end and back-end for the 5-bit combinational arithmetic datapath (add / subtract / absolute sum / signed less-than).
- Accepts one operation command per valid/ready handshake and holds the operands stable on the datapath inputs for a settle window.
- Captures the selected result and overflow flag, then presents them downstream with a valid/ready handshake.
- Keeps a sticky overflow status and a count of completed operations.

Parameters:
- SETTLE_CYCLES, 1: clock edges the operands are held on dp_a/dp_b before capture; legal range 1..15.
- CNT_W, 8: width of op_count.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  block can accept a command
- in_op  in  2  operation code: 00 ADD, 01 SUB, 10 ABS, 11 LT
- in_a  in  5  operand A, two's complement
- in_b  in  5  operand B, two's complement
- dp_a  out  5  operand A driven to the datapath
- dp_b  out  5  operand B driven to the datapath
- dp_sum, dp_abs_sum, dp_diff  in  5 each  datapath results
- dp_of_add, dp_of_sub, dp_lessthan  in  1 each  datapath flags
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_result  out  5  captured result
- out_of  out  1  overflow flag of the captured result
- out_op  out  2  operation code of the captured result
- sticky_of  out  1  sticky overflow status
- clr_sticky  in  1  synchronous clear of sticky_of
- op_count  out  CNT_W  number of completed operations, saturating

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - dp_a, dp_b, out_result, out_op, op_count = 0.
  - out_valid, out_of, sticky_of = 0.
  - Any in-flight operation is dropped.
- States: IDLE, SETTLE, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). The registered path does not depend on in_valid.
- Accept edge (in_valid && in_ready):
  - Load dp_a←in_a, dp_b←in_b, op register←in_op, settle counter←SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE, counter≠0: decrement the counter. dp_a/dp_b are held unchanged throughout SETTLE.
- SETTLE, counter==0 (capture edge):
  - out_result/out_of from the op register:
    - ADD: dp_sum / dp_of_add
    - SUB: dp_diff / dp_of_sub
    - ABS: dp_abs_sum / dp_of_add
    - LT: {4'b0,dp_lessthan} / 0
  - out_op←op register; out_valid←1; go to HOLD.
- Latency: out_valid is high in the cycle after edge (accept + SETTLE_CYCLES). With the default, an accept at edge k gives out_valid visible after edge k+1.
- HOLD:
  - out_result, out_of and out_op are stable while out_valid && !out_ready.
  - On out_ready: out_valid←0 and go to IDLE.
  - If in_valid is also high on that edge, the new command is accepted on the same edge and the state goes directly to SETTLE (zero-bubble back-to-back).
- sticky_of:
  - Set on a capture edge when the captured overflow is 1.
  - Cleared by clr_sticky.
  - If set and clear occur on the same edge, set wins.
- op_count: increments on each capture edge and saturates at 2^CNT_W-1 (no wrap).
- in_valid while not ready: ignored. The command is not latched; the source must hold it.
- dp_a and dp_b change only on accept edges and reset.

Optional Feature:
- Macro ALU5_ACCUM_EN.
- When defined:
  - Opcode bit 2 is added; in_op widens to 3 bits.
  - in_op[2]=1 selects accumulate: dp_a is loaded from the last captured out_result instead of in_a. out_result is 0 after reset.
  - All other behaviour is unchanged.
- When undefined: in_op is 2 bits and no accumulate path exists.

Decomposition:
- Package alu5_pkg:
  - DATA_W=5.
  - op_e enum (ADD, SUB, ABS, LT).
  - seq_state_e enum (IDLE, SETTLE, HOLD).
  - A result struct {result, of, op}.
- One combinational sub-module, alu5_result_sel: maps the op code plus the datapath outputs to {result, of}. It is instantiated once at the capture point.

Test Plan:
- ADD, a=7, b=9, datapath model gives 5'b10000 with OF_add=1 → out_result=5'b10000, out_of=1, sticky_of=1, op_count=1, out_valid two edges after accept.
- SUB, a=3, b=5 → out_result=5'b11110 (-2), out_of=0. ABS, a=-3, b=-4 → out_result=5'b00111.
- LT, a=5'b11100 (-4), b=2 → out_result=5'b00001. LT, a=2, b=-4 → 5'b00000.
- out_ready held low 3 cycles during HOLD → out_result/out_valid stable, in_ready=0.
- Then out_ready=1 together with in_valid=1 (SUB 1-1) → accepted on the same edge, next result 5'b00000.
- Reset asserted mid-SETTLE → all outputs 0 immediately, no out_valid afterwards. clr_sticky on the same edge as an overflowing capture → sticky_of=1.
- SETTLE_CYCLES=4: dp_a/dp_b constant for 4 edges, capture on the 4th edge.
- CNT_W=2 with 5 operations → op_count saturates at 3.

Source files
------------

// File: rtl/alu5_pkg.sv
// -----------------------------------------------------------------------------
// alu5_pkg
// Shared types and constants for the 5-bit ALU operation sequencer.
//   DATA_W      : datapath width (5)
//   OP_W        : width of the command opcode port (2, or 3 with accumulate)
//   op_e        : arithmetic operation select
//   seq_state_e : sequencer FSM states
//   result_t    : captured result bundle {result, of, op}
// Optional feature macro: ALU5_ACCUM_EN (adds opcode bit 2 = accumulate).
// -----------------------------------------------------------------------------
package alu5_pkg;

    localparam int DATA_W = 5;

`ifdef ALU5_ACCUM_EN
    localparam int OP_W = 3;
`else
    localparam int OP_W = 2;
`endif

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ABS = 2'd2,
        OP_LT  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              of;
        op_e               op;
    } result_t;

    // Zero-extends the single-bit less-than flag to a full data word.
    function automatic logic [DATA_W-1:0] lt_to_word(input logic lt);
        return {{(DATA_W-1){1'b0}}, lt};
    endfunction

endpackage

// File: rtl/alu5_op_sequencer_result_sel.sv
// -----------------------------------------------------------------------------
// alu5_result_sel
// Combinational selector: maps the operation code plus the datapath outputs
// to the {result, of, op} bundle that the sequencer captures.
//   op          : operation code
//   dp_sum, dp_abs_sum, dp_diff : datapath results
//   dp_of_add, dp_of_sub, dp_lessthan : datapath flags
//   sel         : selected result bundle
// -----------------------------------------------------------------------------
module alu5_result_sel
    import alu5_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] dp_sum,
    input  logic [DATA_W-1:0] dp_abs_sum,
    input  logic [DATA_W-1:0] dp_diff,
    input  logic              dp_of_add,
    input  logic              dp_of_sub,
    input  logic              dp_lessthan,
    output result_t           sel
);

    // Result/overflow multiplexer; the absolute sum reuses the adder overflow.
    always_comb begin
        sel.op = op;
        case (op)
            OP_ADD: begin
                sel.result = dp_sum;
                sel.of     = dp_of_add;
            end
            OP_SUB: begin
                sel.result = dp_diff;
                sel.of     = dp_of_sub;
            end
            OP_ABS: begin
                sel.result = dp_abs_sum;
                sel.of     = dp_of_add;
            end
            OP_LT: begin
                sel.result = lt_to_word(dp_lessthan);
                sel.of     = 1'b0;
            end
            default: begin
                sel.result = {DATA_W{1'b0}};
                sel.of     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu5_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu5_op_sequencer
// Registered front/back end for the 5-bit combinational arithmetic datapath.
// Accepts a command (valid/ready), holds operands on dp_a/dp_b for
// SETTLE_CYCLES edges, captures the selected result and presents it with a
// valid/ready handshake. Tracks sticky overflow and a saturating op count.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_op/in_a/in_b        : command interface
//   dp_a/dp_b -> datapath; dp_sum/dp_abs_sum/dp_diff/dp_of_add/dp_of_sub/
//   dp_lessthan <- datapath results
//   out_valid/out_ready/out_result/out_of/out_op : result interface
//   sticky_of, clr_sticky, op_count           : status
// Parameters: SETTLE_CYCLES (1..15), CNT_W (op_count width).
// Optional feature macro: ALU5_ACCUM_EN -- in_op[2]=1 loads dp_a from the
// last captured out_result instead of in_a.
// -----------------------------------------------------------------------------
module alu5_op_sequencer
    import alu5_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    input  logic [DATA_W-1:0] dp_sum,
    input  logic [DATA_W-1:0] dp_abs_sum,
    input  logic [DATA_W-1:0] dp_diff,
    input  logic              dp_of_add,
    input  logic              dp_of_sub,
    input  logic              dp_lessthan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_of,
    output logic [1:0]        out_op,
    output logic              sticky_of,
    input  logic              clr_sticky,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    seq_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic              out_valid_q, out_valid_d;
    logic              out_of_q, out_of_d;
    op_e               out_op_q, out_op_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              accept_s;
    logic              capture_s;
    result_t           sel_s;

    alu5_result_sel u_sel (
        .op          (op_q),
        .dp_sum      (dp_sum),
        .dp_abs_sum  (dp_abs_sum),
        .dp_diff     (dp_diff),
        .dp_of_add   (dp_of_add),
        .dp_of_sub   (dp_of_sub),
        .dp_lessthan (dp_lessthan),
        .sel         (sel_s)
    );

    assign accept_s  = in_valid && in_ready;
    assign capture_s = (state_q == ST_SETTLE) && (cnt_q == 4'd0);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; HOLD can hand off straight into SETTLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_SETTLE;
                else          state_d = ST_IDLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) state_d = ST_HOLD;
                else               state_d = ST_SETTLE;
            end
            ST_HOLD: begin
                if (out_ready) state_d = in_valid ? ST_SETTLE : ST_IDLE;
                else           state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready is independent of in_valid.
    always_comb begin
        case (state_q)
            ST_IDLE:   in_ready = 1'b1;
            ST_HOLD:   in_ready = out_ready;
            ST_SETTLE: in_ready = 1'b0;
            default:   in_ready = 1'b0;
        endcase
    end

    // Next values of operand, counter, result and status registers.
    always_comb begin
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        out_result_d = out_result_q;
        out_of_d     = out_of_q;
        out_op_d     = out_op_q;
        out_valid_d  = out_valid_q;
        sticky_d     = sticky_q;
        count_d      = count_q;

        if (accept_s) begin
`ifdef ALU5_ACCUM_EN
            if (in_op[2]) dp_a_d = out_result_q;
            else          dp_a_d = in_a;
`else
            dp_a_d = in_a;
`endif
            dp_b_d = in_b;
            op_d   = op_e'(in_op[1:0]);
            cnt_d  = SETTLE_INIT;
        end else if ((state_q == ST_SETTLE) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (capture_s) begin
            out_result_d = sel_s.result;
            out_of_d     = sel_s.of;
            out_op_d     = sel_s.op;
            out_valid_d  = 1'b1;
        end else if ((state_q == ST_HOLD) && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // Set has priority over a simultaneous clear.
        if (capture_s && sel_s.of) sticky_d = 1'b1;
        else if (clr_sticky)       sticky_d = 1'b0;
        else                       sticky_d = sticky_q;

        if (capture_s && (count_q != CNT_MAX)) count_d = count_q + CNT_W'(1);
        else                                   count_d = count_q;
    end

    // Datapath and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_a_q       <= {DATA_W{1'b0}};
            dp_b_q       <= {DATA_W{1'b0}};
            op_q         <= OP_ADD;
            cnt_q        <= 4'd0;
            out_result_q <= {DATA_W{1'b0}};
            out_of_q     <= 1'b0;
            out_op_q     <= OP_ADD;
            out_valid_q  <= 1'b0;
            sticky_q     <= 1'b0;
            count_q      <= {CNT_W{1'b0}};
        end else begin
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            out_result_q <= out_result_d;
            out_of_q     <= out_of_d;
            out_op_q     <= out_op_d;
            out_valid_q  <= out_valid_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign out_result = out_result_q;
    assign out_of     = out_of_q;
    assign out_op     = out_op_q;
    assign out_valid  = out_valid_q;
    assign sticky_of  = sticky_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu5_op_sequencer.sv
module tb_alu5_op_sequencer;
    import alu5_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Default-parameter instance
    logic            in_valid, in_ready, out_ready, out_valid, out_of, sticky_of, clr_sticky;
    logic [OP_W-1:0] in_op;
    logic [4:0]      in_a, in_b, dp_a, dp_b, dp_sum, dp_abs_sum, dp_diff, out_result;
    logic            dp_of_add, dp_of_sub, dp_lessthan;
    logic [1:0]      out_op;
    logic [7:0]      op_count;

    // SETTLE_CYCLES=4, CNT_W=2 instance
    logic            f_in_valid, f_in_ready, f_out_ready, f_out_valid, f_out_of, f_sticky_of, f_clr_sticky;
    logic [OP_W-1:0] f_in_op;
    logic [4:0]      f_in_a, f_in_b, f_dp_a, f_dp_b, f_dp_sum, f_dp_abs_sum, f_dp_diff, f_out_result;
    logic            f_dp_of_add, f_dp_of_sub, f_dp_lessthan;
    logic [1:0]      f_out_op;
    logic [1:0]      f_op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic exp_sticky = 1'b0;

    // Behavioural datapath: {sum, abs_sum, diff, of_add, of_sub, lessthan}
    function automatic logic [17:0] dp_model(input logic [4:0] a, input logic [4:0] b);
        int sa, sb, s, d, m;
        logic ofa, ofs, lt;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s = sa + sb;
        d = sa - sb;
        m = (s < 0) ? -s : s;
        ofa = (s > 15) || (s < -16);
        ofs = (d > 15) || (d < -16);
        lt = (sa < sb);
        return {s[4:0], m[4:0], d[4:0], ofa, ofs, lt};
    endfunction

    // Expected {of, result} for an operation on the command operands.
    function automatic logic [5:0] ref_op(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
        logic [17:0] r;
        r = dp_model(a, b);
        case (op)
            2'd0:    return {r[2], r[17:13]};
            2'd1:    return {r[1], r[7:3]};
            2'd2:    return {r[2], r[12:8]};
            default: return {1'b0, 4'b0000, r[0]};
        endcase
    endfunction

    assign {dp_sum, dp_abs_sum, dp_diff, dp_of_add, dp_of_sub, dp_lessthan} = dp_model(dp_a, dp_b);
    assign {f_dp_sum, f_dp_abs_sum, f_dp_diff, f_dp_of_add, f_dp_of_sub, f_dp_lessthan} = dp_model(f_dp_a, f_dp_b);

    alu5_op_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .dp_a(dp_a), .dp_b(dp_b), .dp_sum(dp_sum),
        .dp_abs_sum(dp_abs_sum), .dp_diff(dp_diff), .dp_of_add(dp_of_add),
        .dp_of_sub(dp_of_sub), .dp_lessthan(dp_lessthan), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_of(out_of), .out_op(out_op),
        .sticky_of(sticky_of), .clr_sticky(clr_sticky), .op_count(op_count)
    );

    alu5_op_sequencer #(.SETTLE_CYCLES(4), .CNT_W(2)) dut4 (
        .clk(clk), .reset(reset), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_op(f_in_op),
        .in_a(f_in_a), .in_b(f_in_b), .dp_a(f_dp_a), .dp_b(f_dp_b), .dp_sum(f_dp_sum),
        .dp_abs_sum(f_dp_abs_sum), .dp_diff(f_dp_diff), .dp_of_add(f_dp_of_add),
        .dp_of_sub(f_dp_of_sub), .dp_lessthan(f_dp_lessthan), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .out_result(f_out_result), .out_of(f_out_of), .out_op(f_out_op),
        .sticky_of(f_sticky_of), .clr_sticky(f_clr_sticky), .op_count(f_op_count)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE, wait for the result, stall, then drain it.
    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input int stall, output logic [4:0] res, output logic of);
        int n;
        in_valid = 1'b1; in_op = OP_W'(op); in_a = a; in_b = b;
        step;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step; n++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout got out_valid=%b want 1", out_valid);
        end
        res = out_result;
        of  = out_of;
        checks++;
        if (out_op !== op) begin
            errors++;
            $display("FAIL send_out_op got %0d want %0d", out_op, op);
        end
        repeat (stall) step;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        exp_cnt++;
        exp_sticky = exp_sticky | of;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step; step;
        checks++;
        if ({dp_a, dp_b, out_result, out_op, op_count, out_valid, out_of, sticky_of} !== 30'd0) begin
            errors++;
            $display("FAIL reset_state got %h want 0",
                     {dp_a, dp_b, out_result, out_op, op_count, out_valid, out_of, sticky_of});
        end
        reset = 1'b0;
        step;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        exp_cnt = 0; exp_sticky = 1'b0;
    endtask

    task automatic test_add_latency;
        in_valid = 1'b1; in_op = OP_W'(2'd0); in_a = 5'd7; in_b = 5'd9;
        step;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || dp_a !== 5'd7 || dp_b !== 5'd9) begin
            errors++;
            $display("FAIL add_accept got valid=%b dp_a=%0d dp_b=%0d want 0/7/9", out_valid, dp_a, dp_b);
        end
        step;
        checks++;
        if ({out_valid, out_result, out_of, sticky_of, op_count} !== {1'b1, 5'b10000, 1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL add_capture got v=%b r=%b of=%b st=%b cnt=%0d want 1/10000/1/1/1",
                     out_valid, out_result, out_of, sticky_of, op_count);
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain got out_valid=%b want 0", out_valid);
        end
        exp_cnt = 1; exp_sticky = 1'b1;
    endtask

    task automatic test_ops;
        logic [1:0]  ops  [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        logic [4:0]  as   [4] = '{5'd3, 5'b11101, 5'b11100, 5'd2};
        logic [4:0]  bs   [4] = '{5'd5, 5'b11100, 5'd2, 5'b11100};
        logic [4:0]  exps [4] = '{5'b11110, 5'b00111, 5'b00001, 5'b00000};
        logic [4:0] r;
        logic o;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], as[i], bs[i], 0, r, o);
            checks++;
            if (r !== exps[i] || o !== 1'b0) begin
                errors++;
                $display("FAIL ops_%0d got %b of=%b want %b of=0", i, r, o, exps[i]);
            end
        end
    endtask

    task automatic test_stall_back_to_back;
        in_valid = 1'b1; in_op = OP_W'(2'd0); in_a = 5'd1; in_b = 5'd2;
        step;
        in_valid = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 5'd3 || out_op !== 2'd0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d got v=%b r=%0d op=%0d rdy=%b want 1/3/0/0",
                         i, out_valid, out_result, out_op, in_ready);
            end
            step;
        end
        out_ready = 1'b1; in_valid = 1'b1; in_op = OP_W'(2'd1); in_a = 5'd1; in_b = 5'd1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b want 1", in_ready);
        end
        step;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || dp_a !== 5'd1 || dp_b !== 5'd1) begin
            errors++;
            $display("FAIL b2b_accept got v=%b dp_a=%0d dp_b=%0d want 0/1/1", out_valid, dp_a, dp_b);
        end
        step;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 5'd0 || out_of !== 1'b0 || out_op !== 2'd1) begin
            errors++;
            $display("FAIL b2b_result got v=%b r=%b of=%b op=%0d want 1/00000/0/1",
                     out_valid, out_result, out_of, out_op);
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        exp_cnt += 2;
    endtask

    task automatic test_sticky;
        clr_sticky = 1'b1;
        step;
        clr_sticky = 1'b0;
        checks++;
        if (sticky_of !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear got %b want 0", sticky_of);
        end
        in_valid = 1'b1; in_op = OP_W'(2'd0); in_a = 5'd8; in_b = 5'd8;
        step;
        in_valid = 1'b0; clr_sticky = 1'b1;
        step;
        clr_sticky = 1'b0;
        checks++;
        if (sticky_of !== 1'b1 || out_result !== 5'b10000 || out_of !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins got st=%b r=%b of=%b want 1/10000/1", sticky_of, out_result, out_of);
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        exp_cnt++;
        exp_sticky = 1'b1;
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [4:0] a, b, r;
        logic o;
        logic [5:0] e;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 5'($urandom);
            b  = 5'($urandom);
            e  = ref_op(op, a, b);
            send(op, a, b, int'($urandom_range(0, 2)), r, o);
            checks++;
            if ({o, r} !== e) begin
                errors++;
                $display("FAIL rand_%0d op=%0d a=%b b=%b got of=%b r=%b want of=%b r=%b",
                         i, op, a, b, o, r, e[5], e[4:0]);
            end
        end
        checks++;
        if (op_count !== 8'(exp_cnt) || sticky_of !== exp_sticky) begin
            errors++;
            $display("FAIL rand_status got cnt=%0d st=%b want cnt=%0d st=%b",
                     op_count, sticky_of, exp_cnt, exp_sticky);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        in_valid = 1'b1; in_op = OP_W'(2'd0); in_a = 5'd9; in_b = 5'd9;
        step;
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({dp_a, dp_b, out_result, out_op, op_count, out_valid, out_of, sticky_of} !== 30'd0) begin
            errors++;
            $display("FAIL reset_mid_state got %h want 0",
                     {dp_a, dp_b, out_result, out_op, op_count, out_valid, out_of, sticky_of});
        end
        step;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step;
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_no_valid got %0d valid cycles want 0", bad);
        end
        exp_cnt = 0; exp_sticky = 1'b0;
    endtask

    // Four-cycle settle instance: operand hold window and capture edge.
    task automatic test_settle4;
        int bad;
        f_in_valid = 1'b1; f_in_op = OP_W'(2'd1); f_in_a = 5'd10; f_in_b = 5'd3;
        step;
        f_in_valid = 1'b0;
        bad = 0;
        for (int i = 1; i <= 4; i++) begin
            if (f_dp_a !== 5'd10 || f_dp_b !== 5'd3) bad++;
            step;
            if (f_out_valid !== (i == 4)) begin
                errors++;
                $display("FAIL settle4_valid_edge%0d got %b want %b", i, f_out_valid, (i == 4));
            end
            checks++;
        end
        checks++;
        if (bad != 0 || f_out_result !== 5'd7 || f_op_count !== 2'd1) begin
            errors++;
            $display("FAIL settle4_result got bad=%0d r=%0d cnt=%0d want 0/7/1", bad, f_out_result, f_op_count);
        end
        f_out_ready = 1'b1;
        step;
        f_out_ready = 1'b0;
    endtask

    // Two-bit counter saturates at 3 after five operations.
    task automatic test_saturate;
        int n;
        for (int k = 2; k <= 5; k++) begin
            f_in_valid = 1'b1; f_in_op = OP_W'(2'd0); f_in_a = 5'(k); f_in_b = 5'd1;
            step;
            f_in_valid = 1'b0;
            n = 0;
            while (!f_out_valid && n < 20) begin step; n++; end
            checks++;
            if (f_out_valid !== 1'b1 || f_op_count !== 2'((k < 3) ? k : 3)) begin
                errors++;
                $display("FAIL saturate_op%0d got v=%b cnt=%0d want 1/%0d",
                         k, f_out_valid, f_op_count, (k < 3) ? k : 3);
            end
            f_out_ready = 1'b1;
            step;
            f_out_ready = 1'b0;
        end
    endtask

    initial begin
        in_valid = 1'b0; in_op = '0; in_a = 5'd0; in_b = 5'd0; out_ready = 1'b0; clr_sticky = 1'b0;
        f_in_valid = 1'b0; f_in_op = '0; f_in_a = 5'd0; f_in_b = 5'd0; f_out_ready = 1'b0; f_clr_sticky = 1'b0;
        reset = 1'b0;
        test_reset();
        test_add_latency();
        test_ops();
        test_stall_back_to_back();
        test_sticky();
        test_random();
        test_reset_mid();
        test_settle4();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
